// File: rtl/spi_slave_ctrl.sv
// SPI mode-0 slave frame controller driving the SPI-ALU shift register.
// Define SPI_CTRL_MISO_TRISTATE_EN to float miso while the FSM is in IDLE.
module spi_slave_ctrl #(
  parameter int BIT_LENGTH = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
  input  logic q_lsb,
  output logic shift_en,
  output logic load_en,
  output logic serial_in,
  output logic miso,
  output logic busy,
  output logic rx_valid,
  output logic frame_err
);

  localparam int CW = $clog2(BIT_LENGTH + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] ACTIVE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]    state;
  logic          sclk_m, sclk_s, sclk_d;
  logic          cs_n_m, cs_n_s, cs_n_d;
  logic          mosi_m, mosi_s;
  logic [1:0]    flush_cnt;
  logic          armed;
  logic [CW-1:0] bit_cnt;
  logic          rx_pend;
  logic          prime;
  logic          miso_q;
  logic          sclk_rise, sclk_fall, cs_fall;

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_m    <= 1'b0;
      sclk_s    <= 1'b0;
      sclk_d    <= 1'b0;
      cs_n_m    <= 1'b1;
      cs_n_s    <= 1'b1;
      cs_n_d    <= 1'b1;
      mosi_m    <= 1'b0;
      mosi_s    <= 1'b0;
      flush_cnt <= 2'd0;
    end else begin
      sclk_m    <= sclk;
      sclk_s    <= sclk_m;
      sclk_d    <= sclk_s;
      cs_n_m    <= cs_n;
      cs_n_s    <= cs_n_m;
      cs_n_d    <= cs_n_s;
      mosi_m    <= mosi;
      mosi_s    <= mosi_m;
      // Counts edges since reset so the reset-forced high on cs_n_s is never mistaken for a real release.
      if (flush_cnt != 2'd3) flush_cnt <= flush_cnt + 2'd1;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_fall   = ~cs_n_s & cs_n_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shift_en  <= 1'b0;
      load_en   <= 1'b0;
      serial_in <= 1'b0;
      miso_q    <= 1'b0;
      busy      <= 1'b0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      armed     <= 1'b0;
      bit_cnt   <= '0;
      rx_pend   <= 1'b0;
      prime     <= 1'b0;
    end else begin
      shift_en  <= 1'b0;
      load_en   <= 1'b0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      prime     <= load_en;

      case (state)
        IDLE: begin
          busy   <= 1'b0;
          miso_q <= 1'b0;
          // A frame may only start after chip select has genuinely been seen high.
          if (flush_cnt[1] && cs_n_s) armed <= 1'b1;
          if (armed && cs_fall) begin
            state <= LOAD;
            busy  <= 1'b1;
            armed <= 1'b0;
          end
        end

        LOAD: begin
          load_en <= 1'b1;
          bit_cnt <= '0;
          state   <= ACTIVE;
        end

        ACTIVE: begin
          // A high chip select aborts; the level test also covers a release landing during LOAD.
          if (cs_n_s) begin
            frame_err <= 1'b1;
            state     <= IDLE;
            busy      <= 1'b0;
            miso_q    <= 1'b0;
          end else begin
            if (sclk_rise) begin
              shift_en  <= 1'b1;
              serial_in <= mosi_s;
              bit_cnt   <= bit_cnt + CW'(1);
              if (bit_cnt == CW'(BIT_LENGTH - 1)) begin
                state   <= DONE;
                rx_pend <= 1'b1;
              end
            end
            // prime presents bit 0 once the shift register has taken the TX word.
            if (sclk_fall || prime) miso_q <= q_lsb;
          end
        end

        DONE: begin
          rx_valid <= rx_pend;
          rx_pend  <= 1'b0;
          if (cs_n_s) begin
            state  <= IDLE;
            busy   <= 1'b0;
            miso_q <= 1'b0;
          end else if (sclk_rise) begin
            frame_err <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_CTRL_MISO_TRISTATE_EN
  assign miso = (state == IDLE) ? 1'bz : miso_q;
`else
  assign miso = miso_q;
`endif

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Bench for spi_slave_ctrl: a behavioural shift register stands in for the ALU
// and a frame-level model predicts pulse counts, received word and MISO stream.
module tb_spi_slave_ctrl;
  localparam int BL   = 20;
  localparam int HALF = 5;

`ifdef SPI_CTRL_MISO_TRISTATE_EN
  localparam logic IDLE_MISO = 1'bz;
`else
  localparam logic IDLE_MISO = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, sclk, cs_n, mosi, q_lsb;
  logic shift_en, load_en, serial_in, miso, busy, rx_valid, frame_err;
  logic [BL-1:0] q = '0;
  logic [BL-1:0] tx_word = '0;
  logic [BL-1:0] rx_q = '0;
  int load_cnt = 0, shift_cnt = 0, rxv_cnt = 0, err_cnt = 0;
  int checks = 0, errors = 0;

  typedef struct {
    logic [BL-1:0] tx;
    logic [BL-1:0] rx;
    int            nclk;
    int            exp_shift;
    int            exp_rxv;
    int            exp_err;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  spi_slave_ctrl #(.BIT_LENGTH(BL)) dut (
    .clk       (clk),
    .reset     (reset),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .q_lsb     (q_lsb),
    .shift_en  (shift_en),
    .load_en   (load_en),
    .serial_in (serial_in),
    .miso      (miso),
    .busy      (busy),
    .rx_valid  (rx_valid),
    .frame_err (frame_err)
  );

  // Stand-in for the SPI-ALU shift register: loads TX word, shifts received bits in at the MSB.
  assign q_lsb = q[0];
  always @(posedge clk) begin
    if (load_en) q <= tx_word;
    else if (shift_en) q <= {serial_in, q[BL-1:1]};
  end

  always @(negedge clk) begin
    if (load_en)   load_cnt++;
    if (shift_en)  shift_cnt++;
    if (frame_err) err_cnt++;
    if (rx_valid) begin
      rxv_cnt++;
      rx_q = q;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Frame-level reference: what a master clocking n bits should observe.
  function automatic void model(input int n, output int sh, output int rxv, output int err);
    sh  = (n < BL) ? n : BL;
    rxv = (n >= BL) ? 1 : 0;
    err = (n < BL) ? 1 : n - BL;
  endfunction

  // Drives one SPI frame of n SCLK cycles as a mode-0 master, capturing MISO before each rise.
  task automatic applyStimulus(input logic [BL-1:0] tx, input logic [BL-1:0] rx, input int n,
                               input int gap, output logic [BL-1:0] got);
    got = '0;
    tx_word = tx;
    @(negedge clk) cs_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      mosi = (i < BL) ? rx[i] : 1'($urandom);
      repeat (HALF) @(negedge clk);
      if (i < BL) got[i] = miso;
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    cs_n = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("busy_after_cs_rise", {31'b0, busy}, 32'd0);
    repeat (gap - 4) @(negedge clk);
    checkOutput("miso_idle", {31'b0, miso}, {31'b0, IDLE_MISO});
  endtask

  task automatic checkFrame(input logic [BL-1:0] tx, input logic [BL-1:0] rx, input int n, input int gap,
                            input int exp_shift, input int exp_rxv, input int exp_err);
    int l0, s0, r0, e0;
    logic [BL-1:0] got, mask;
    l0 = load_cnt; s0 = shift_cnt; r0 = rxv_cnt; e0 = err_cnt;
    applyStimulus(tx, rx, n, gap, got);
    checkOutput("load_en_count",   load_cnt - l0,  32'd1);
    checkOutput("shift_en_count",  shift_cnt - s0, exp_shift);
    checkOutput("rx_valid_count",  rxv_cnt - r0,   exp_rxv);
    checkOutput("frame_err_count", err_cnt - e0,   exp_err);
    if (exp_rxv != 0) begin
      checkOutput("rx_word_at_valid", {12'b0, rx_q}, {12'b0, rx});
      checkOutput("rx_word_final",    {12'b0, q},    {12'b0, rx});
    end
    mask = (n >= BL) ? {BL{1'b1}} : BL'((32'd1 << n) - 32'd1);
    if (n > 0) checkOutput("miso_stream", {12'b0, got & mask}, {12'b0, tx & mask});
  endtask

  initial begin
    int sh, rxv, err, n, gap;
    logic [BL-1:0] tx, rx;

    vecs[0] = '{tx: 20'hA5C3E, rx: 20'h5F0A1, nclk: 20, exp_shift: 20, exp_rxv: 1, exp_err: 0};
    vecs[1] = '{tx: 20'h0F0F0, rx: 20'hABCDE, nclk: 7,  exp_shift: 7,  exp_rxv: 0, exp_err: 1};
    vecs[2] = '{tx: 20'h13579, rx: 20'h2468A, nclk: 22, exp_shift: 20, exp_rxv: 1, exp_err: 2};
    vecs[3] = '{tx: 20'hFFFFF, rx: 20'h00000, nclk: 20, exp_shift: 20, exp_rxv: 1, exp_err: 0};
    vecs[4] = '{tx: 20'h00000, rx: 20'hFFFFF, nclk: 20, exp_shift: 20, exp_rxv: 1, exp_err: 0};
    vecs[5] = '{tx: 20'h12345, rx: 20'h54321, nclk: 0,  exp_shift: 0,  exp_rxv: 0, exp_err: 1};
    vecs[6] = '{tx: 20'h80001, rx: 20'h7FFFE, nclk: 19, exp_shift: 19, exp_rxv: 0, exp_err: 1};

    reset = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_shift_en",  {31'b0, shift_en},  32'd0);
    checkOutput("reset_load_en",   {31'b0, load_en},   32'd0);
    checkOutput("reset_serial_in", {31'b0, serial_in}, 32'd0);
    checkOutput("reset_miso",      {31'b0, miso},      {31'b0, IDLE_MISO});
    checkOutput("reset_busy",      {31'b0, busy},      32'd0);
    checkOutput("reset_rx_valid",  {31'b0, rx_valid},  32'd0);
    checkOutput("reset_frame_err", {31'b0, frame_err}, 32'd0);
    reset = 1'b0;
    repeat (6) @(negedge clk);

    $display("[TB] latency sequence");
    tx_word = 20'h00001;
    cs_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("load_en_edge3", {31'b0, load_en}, 32'd0);
    @(negedge clk);
    checkOutput("load_en_edge4", {31'b0, load_en}, 32'd1);
    checkOutput("busy_in_frame", {31'b0, busy},    32'd1);
    repeat (8) @(negedge clk);
    mosi = 1'b1;
    repeat (2) @(negedge clk);
    sclk = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("shift_en_edge2", {31'b0, shift_en}, 32'd0);
    @(negedge clk);
    checkOutput("shift_en_edge3",  {31'b0, shift_en},  32'd1);
    checkOutput("serial_in_edge3", {31'b0, serial_in}, 32'd1);
    repeat (HALF) @(negedge clk);
    sclk = 1'b0;
    repeat (HALF) @(negedge clk);
    cs_n = 1'b1;
    repeat (10) @(negedge clk);

    $display("[TB] vector table");
    for (int i = 0; i < 7; i++)
      checkFrame(vecs[i].tx, vecs[i].rx, vecs[i].nclk, 8, vecs[i].exp_shift, vecs[i].exp_rxv, vecs[i].exp_err);

    $display("[TB] back-to-back frames");
    checkFrame(20'h6B1D2, 20'h3E7C5, 20, 4, 20, 1, 0);
    checkFrame(20'h1A2B3, 20'hC4D5E, 20, 8, 20, 1, 0);

    $display("[TB] random frames");
    for (int i = 0; i < 8; i++) begin
      tx  = BL'($urandom);
      rx  = BL'($urandom);
      n   = int'($urandom_range(0, 24));
      gap = int'($urandom_range(4, 10));
      model(n, sh, rxv, err);
      checkFrame(tx, rx, n, gap, sh, rxv, err);
    end

    $display("[TB] reset mid-frame");
    begin
      int l0;
      tx_word = 20'h3C3C3;
      mosi = 1'b1;
      cs_n = 1'b0;
      repeat (8) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
        repeat (HALF) @(negedge clk);
        sclk = 1'b1;
        repeat (HALF) @(negedge clk);
        sclk = 1'b0;
      end
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("midrst_shift_en",  {31'b0, shift_en},  32'd0);
      checkOutput("midrst_load_en",   {31'b0, load_en},   32'd0);
      checkOutput("midrst_serial_in", {31'b0, serial_in}, 32'd0);
      checkOutput("midrst_miso",      {31'b0, miso},      {31'b0, IDLE_MISO});
      checkOutput("midrst_busy",      {31'b0, busy},      32'd0);
      checkOutput("midrst_rx_valid",  {31'b0, rx_valid},  32'd0);
      checkOutput("midrst_frame_err", {31'b0, frame_err}, 32'd0);
      reset = 1'b0;
      l0 = load_cnt;
      for (int i = 0; i < 3; i++) begin
        repeat (HALF) @(negedge clk);
        sclk = 1'b1;
        repeat (HALF) @(negedge clk);
        sclk = 1'b0;
      end
      checkOutput("held_low_busy",  {31'b0, busy}, 32'd0);
      checkOutput("held_low_loads", load_cnt - l0, 32'd0);
      cs_n = 1'b1;
      repeat (8) @(negedge clk);
      checkFrame(20'hA5C3E, 20'h5F0A1, 20, 8, 20, 1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_ctrl.md
# spi_slave_ctrl

SPI slave frame controller (mode 0, LSB-first) that sits directly upstream of the SPI-ALU shift register and drives its `shift_en`, `load_en` and `serial_in` inputs. It synchronises the raw SPI pins into the system clock domain, counts bits and loads the transmit word at frame start. It returns the shift register's LSB on MISO and flags frame completion or abort to the ALU control logic.

## Interface
- `BIT_LENGTH`, 20, frame length in bits; must equal the shift register width.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sclk`  in  1  raw SPI clock, asynchronous.
- `cs_n`  in  1  raw chip select, active low, asynchronous.
- `mosi`  in  1  raw serial data in, asynchronous.
- `q_lsb`  in  1  bit 0 of the shift register output (next bit to transmit).
- `shift_en`  out  1  one-cycle pulse; shift register shifts in `serial_in`.
- `load_en`  out  1  one-cycle pulse; shift register loads its parallel input (TX word).
- `serial_in`  out  1  synchronised MOSI bit, valid when `shift_en`=1.
- `miso`  out  1  serial data out.
- `busy`  out  1  high from frame start until return to IDLE.
- `rx_valid`  out  1  one-cycle pulse; shift register holds a complete received word.
- `frame_err`  out  1  one-cycle pulse; frame aborted or over-clocked.

## Operation
- Synchronisation: `sclk`, `cs_n`, `mosi` each pass through 2 flops (`*_s`); `sclk_s` and `cs_n_s` are delayed once more for edge detect. Reset value of sync flops: `sclk`=0, `cs_n`=1, `mosi`=0.
- Bit counter `bit_cnt`, width `$clog2(BIT_LENGTH+1)`, reset 0.
- FSM states IDLE, LOAD, ACTIVE, DONE; reset to IDLE.
- IDLE: on `cs_n_s` falling edge go to LOAD.
- LOAD: `load_en`=1 for one cycle, `bit_cnt`<=0, go to ACTIVE.
- ACTIVE:
  - `sclk_s` rising edge: `shift_en`=1, `serial_in`<=`mosi_s`, `bit_cnt`++.
  - On the shift that makes `bit_cnt`==BIT_LENGTH, go to DONE.
  - `sclk_s` falling edge: `miso`<=`q_lsb`.
  - `cs_n_s` rising edge before count reaches BIT_LENGTH: `frame_err` pulse, go to IDLE; no `rx_valid`.
- DONE:
  - `rx_valid` pulses in the first DONE cycle only.
  - Further `sclk_s` rising edges: no `shift_en`, `frame_err` pulse per edge.
  - `cs_n_s` rising edge: go to IDLE.
- `miso` also updates from `q_lsb` in the cycle after LOAD, so bit 0 is present before the first SCLK rise.
- `busy`=1 in LOAD, ACTIVE and DONE.
- Reset values of outputs: `shift_en`=0, `load_en`=0, `serial_in`=0, `miso`=0, `busy`=0, `rx_valid`=0, `frame_err`=0.
- Simultaneous events:
  - `cs_n_s` rise with `sclk_s` rise in the same cycle in ACTIVE: abort wins, no shift.
  - `reset` mid-frame: immediate return to IDLE. A new frame starts only on a subsequent `cs_n` falling edge; if `cs_n` is already low at reset release, no frame starts until it goes high and falls again.

## Timing
- All outputs are registered.
- `shift_en` and `serial_in` appear 3 `clk` edges after the raw `sclk` rise: 2 sync edges plus 1 register edge.
- `load_en` is asserted 4 `clk` edges after the raw `cs_n` fall.
- `rx_valid` occurs in the cycle after the final `shift_en`; Q is already updated when it is sampled.
- `miso` changes 3 `clk` edges after the raw `sclk` fall.
- Requirement: `clk` ≥ 8× `sclk`, and `cs_n` setup ≥ 4 `clk` cycles before the first `sclk` rise.

## Configuration
- `SPI_CTRL_MISO_TRISTATE_EN` defined: `miso` is driven `1'bz` whenever the FSM is in IDLE, including during reset.
- Without the macro: `miso` is driven 0 in IDLE.
- Behaviour in all other states is identical with or without the macro.

## Test plan
- Full frame: BIT_LENGTH=20, TX word 0xA5C3E, MOSI LSB-first 0x5F0A1, 20 SCLK cycles → exactly one `load_en`, 20 `shift_en`, one `rx_valid`. Shift register Q=0x5F0A1; MISO bit sequence equals 0xA5C3E LSB-first.
- Early abort: `cs_n` raised after 7 SCLK cycles → `frame_err` pulse, no `rx_valid`, `busy`=0 within 4 cycles.
- Over-clock: 22 SCLK cycles in one frame → 20 `shift_en`, `rx_valid` once, 2 `frame_err` pulses, Q unchanged after bit 20.
- Reset mid-frame: `reset` asserted at bit 10 with `cs_n` held low → IDLE, all outputs 0. After `cs_n` high then low again, a new full frame completes normally.
- Back-to-back frames separated by 4 `clk` of `cs_n` high → two `load_en`, two `rx_valid`, correct words.
- Macro: with `SPI_CTRL_MISO_TRISTATE_EN`, `miso`=z in IDLE; without it, `miso`=0 in IDLE.
